// File: rtl/pattern_ser_pkg.sv
// pattern_ser_pkg: shared types and helpers for the pattern serializer (rev 1.0)
`timescale 1ns/1ps
`default_nettype none
package pattern_ser_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } ser_state_t;

  localparam int PAT_W = 16;

  // Divider reload value: a programmed 0 behaves like 1 clk per bit.
  function automatic logic [15:0] div_reload(input logic [15:0] d);
    return (d == 16'd0) ? 16'd0 : d - 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_ser_fifo.sv
// pattern_ser_fifo: DEPTH x WIDTH show-ahead register FIFO with occupancy (rev 1.0)
`timescale 1ns/1ps
`default_nettype none
module pattern_ser_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pattern_serializer.sv
// pattern_serializer: buffers pattern words and shifts them out MSB-first with a frame strobe (rev 1.0)
// Optional even-parity trailer bit when PATTERN_SER_PARITY_EN is defined.
`timescale 1ns/1ps
`default_nettype none
module pattern_serializer
  import pattern_ser_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = PAT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [15:0]              bit_div,
  input  logic                     pat_valid,
  input  logic [WIDTH-1:0]         pat_data,
  output logic                     pat_ready,
  output logic                     ser_out,
  output logic                     ser_frame,
  output logic                     busy,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

`ifdef PATTERN_SER_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int CW = $clog2(NB);

  ser_state_t       r_state, w_state_nxt;
  logic [NB-1:0]    r_shreg, w_shreg_nxt;
  logic [CW-1:0]    r_bit_cnt, w_bit_nxt;
  logic [15:0]      r_div_cnt, w_div_nxt;
  logic             r_ser_out, w_ser_nxt;
  logic             r_frame, w_frame_nxt;
  logic             r_underrun, w_underrun_nxt;
  logic             r_en_d;

  logic [WIDTH-1:0] w_head;
  logic [NB-1:0]    w_word;
  logic             w_full, w_empty, w_pop, w_go, w_early;
  logic [15:0]      w_reload;

  pattern_ser_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (pat_valid),
    .i_data  (pat_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

`ifdef PATTERN_SER_PARITY_EN
  assign w_word = {w_head, ^w_head};
`else
  assign w_word = w_head;
`endif

  assign w_reload = div_reload(bit_div);
  assign w_go     = enable & ~w_empty;
  // The LOAD cycle overlaps the last clk of the outgoing word, so the
  // follow-on decision is taken one clk before the final bit period ends.
  assign w_early  = ((r_bit_cnt == '0) && (r_div_cnt == 16'd1)) ||
                    ((r_bit_cnt == CW'(1)) && (r_div_cnt == 16'd0) && (w_reload == 16'd0));

  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_bit_nxt      = r_bit_cnt;
    w_div_nxt      = r_div_cnt;
    w_ser_nxt      = r_ser_out;
    w_frame_nxt    = r_frame;
    w_underrun_nxt = r_underrun;
    w_pop          = 1'b0;
    if (enable && !r_en_d) w_underrun_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_word;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ser_nxt   = r_shreg[NB-1];
        w_shreg_nxt = r_shreg << 1;
        w_bit_nxt   = CW'(NB - 1);
        w_div_nxt   = w_reload;
        w_frame_nxt = 1'b1;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (r_div_cnt != 16'd0) begin
          w_div_nxt = r_div_cnt - 16'd1;
        end else if (r_bit_cnt != '0) begin
          w_ser_nxt   = r_shreg[NB-1];
          w_shreg_nxt = r_shreg << 1;
          w_bit_nxt   = r_bit_cnt - CW'(1);
          w_div_nxt   = w_reload;
        end else begin
          w_state_nxt = S_IDLE;
          w_frame_nxt = 1'b0;
          w_ser_nxt   = 1'b0;
          if (enable && w_empty) w_underrun_nxt = 1'b1;
        end
        if (w_early && w_go) begin
          w_pop       = 1'b1;
          w_shreg_nxt = w_word;
          w_state_nxt = S_LOAD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_frame_nxt = 1'b0;
        w_ser_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_ser_out  <= 1'b0;
      r_frame    <= 1'b0;
      r_underrun <= 1'b0;
      r_en_d     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_div_cnt  <= w_div_nxt;
      r_ser_out  <= w_ser_nxt;
      r_frame    <= w_frame_nxt;
      r_underrun <= w_underrun_nxt;
      r_en_d     <= enable;
    end
  end

  assign pat_ready = ~w_full;
  assign ser_out   = r_ser_out;
  assign ser_frame = r_frame;
  assign busy      = (r_state != S_IDLE);
  assign underrun  = r_underrun;

endmodule
`default_nettype wire
